// File: rtl/bus_write_dec.sv
// Write-side bus decoder: loads one of 15 datapath registers from bus_in and runs req/ack memory writes.
// Optional feature macro PC_INC_EN adds an inc_pc input that auto-increments pc.
module bus_write_dec #(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PC_INC_EN
  input  logic             inc_pc,
`endif
  input  logic [WIDTH-1:0] bus_in,
  input  logic [4:0]       write_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] dar,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] tr,
  output logic [WIDTH-1:0] ri,
  output logic [WIDTH-1:0] rj,
  output logic [WIDTH-1:0] rk,
  output logic [WIDTH-1:0] ti,
  output logic [WIDTH-1:0] tj,
  output logic [WIDTH-1:0] tk,
  output logic [WIDTH-1:0] ao,
  output logic [WIDTH-1:0] tar,
  output logic [WIDTH-1:0] e,
  output logic             mem_req,
  output logic             mem_sel,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             mem_err,
  output logic             o_dbg_state
);

  // Handshake: mem_req is a level held from launch until the cycle after mem_ack
  // (or the timeout abort); mem_addr/mem_wdata/mem_sel are stable while mem_req is high.

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_e;

  localparam logic [4:0] CODE_DM = 5'd16;
  localparam logic [4:0] CODE_IM = 5'd17;
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  logic             w_launch;
  logic             w_ack_done;
  logic             w_timeout;
  logic             w_mem_code;
  logic [7:0]       r_count;
  logic [WIDTH-1:0] r_file [15];
  logic             r_mem_req;
  logic             r_mem_sel;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_busy;
  logic             r_mem_err;

  assign w_mem_code = (write_en == CODE_DM) || (write_en == CODE_IM);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_ack_done = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_code) begin
          w_launch = 1'b1;
          w_next   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Ack has priority over a coinciding timeout.
        if (mem_ack) begin
          w_ack_done = 1'b1;
          w_next     = IDLE;
        end else if (r_count == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Register file: loads are independent of the memory FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_file[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (write_en == 5'(i + 1)) r_file[i] <= bus_in;
      end
`ifdef PC_INC_EN
      if (inc_pc && (write_en != 5'd1)) r_file[0] <= r_file[0] + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_mem_err   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_mem_err <= w_timeout;
      if (w_launch) begin
        // Address is the pre-update dar/pc value.
        r_mem_addr  <= write_en[0] ? r_file[0] : r_file[1];
        r_mem_wdata <= bus_in;
        r_mem_sel   <= write_en[0];
        r_mem_req   <= 1'b1;
        r_busy      <= 1'b1;
        r_count     <= '0;
      end else if (w_ack_done || w_timeout) begin
        r_mem_req <= 1'b0;
        r_busy    <= 1'b0;
      end else if (r_state == WAIT_ACK) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign pc          = r_file[0];
  assign dar         = r_file[1];
  assign ir          = r_file[2];
  assign ac          = r_file[3];
  assign r           = r_file[4];
  assign tr          = r_file[5];
  assign ri          = r_file[6];
  assign rj          = r_file[7];
  assign rk          = r_file[8];
  assign ti          = r_file[9];
  assign tj          = r_file[10];
  assign tk          = r_file[11];
  assign ao          = r_file[12];
  assign tar         = r_file[13];
  assign e           = r_file[14];
  assign mem_req     = r_mem_req;
  assign mem_sel     = r_mem_sel;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = r_busy;
  assign mem_err     = r_mem_err;
  assign o_dbg_state = (r_state == WAIT_ACK);

endmodule

// File: tb/tb_bus_write_dec.sv
// Directed bench for bus_write_dec: register loads, dm/im writes, timeout, busy loads, reset mid-op.
module tb_bus_write_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc_pc = 1'b0;
  logic [15:0] bus_in = '0;
  logic [4:0]  write_en = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] pc, dar, ir, ac, r, tr, ri, rj, rk, ti, tj, tk, ao, tar, e;
  logic        mem_req, mem_sel, busy, mem_err, dbg_state;
  logic [15:0] mem_addr, mem_wdata;

  logic [15:0] dut_regs [15];
  logic [15:0] exp_regs [15];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_write_dec #(.WIDTH(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PC_INC_EN
    .inc_pc(inc_pc),
`endif
    .bus_in(bus_in), .write_en(write_en),
    .pc(pc), .dar(dar), .ir(ir), .ac(ac), .r(r), .tr(tr), .ri(ri), .rj(rj), .rk(rk),
    .ti(ti), .tj(tj), .tk(tk), .ao(ao), .tar(tar), .e(e),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .mem_err(mem_err), .o_dbg_state(dbg_state)
  );

  assign dut_regs[0]  = pc;  assign dut_regs[1]  = dar; assign dut_regs[2]  = ir;
  assign dut_regs[3]  = ac;  assign dut_regs[4]  = r;   assign dut_regs[5]  = tr;
  assign dut_regs[6]  = ri;  assign dut_regs[7]  = rj;  assign dut_regs[8]  = rk;
  assign dut_regs[9]  = ti;  assign dut_regs[10] = tj;  assign dut_regs[11] = tk;
  assign dut_regs[12] = ao;  assign dut_regs[13] = tar; assign dut_regs[14] = e;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; write_en = 5'd4; bus_in = 16'h1234;
    tick();
    for (int i = 0; i < 15; i++) exp_regs[i] = '0;
    for (int i = 0; i < 15; i++) begin
      n_tests++;
      if (dut_regs[i] !== exp_regs[i]) begin
        n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", i + 1, dut_regs[i], exp_regs[i]);
      end
    end
    n_tests++;
    if ({mem_req, busy, mem_err, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got req/busy/err/st=%b exp=0000", {mem_req, busy, mem_err, dbg_state});
    end
    rst_n = 1'b1; write_en = 5'd0;
    tick();
  endtask

  task automatic test_loads();
    for (int c = 1; c <= 15; c++) begin
      write_en = 5'(c); bus_in = 16'hA000 + 16'(c);
      tick();
      exp_regs[c - 1] = 16'hA000 + 16'(c);
      for (int i = 0; i < 15; i++) begin
        n_tests++;
        if (dut_regs[i] !== exp_regs[i]) begin
          n_fail++; $display("FAIL load_code%0d_reg%0d got=%h exp=%h", c, i + 1, dut_regs[i], exp_regs[i]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      write_en = (k == 0) ? 5'd0 : 5'd20; bus_in = 16'hFFFF;
      tick();
      for (int i = 0; i < 15; i++) begin
        n_tests++;
        if (dut_regs[i] !== exp_regs[i]) begin
          n_fail++; $display("FAIL noop_code%0d_reg%0d got=%h exp=%h", write_en, i + 1, dut_regs[i], exp_regs[i]);
        end
      end
      n_tests++;
      if (mem_req !== 1'b0) begin
        n_fail++; $display("FAIL noop_req got=%b exp=0", mem_req);
      end
    end
    write_en = 5'd0;
  endtask

  task automatic test_dm_write();
    write_en = 5'd2; bus_in = 16'h0040;
    tick();
    exp_regs[1] = 16'h0040;
    write_en = 5'd16; bus_in = 16'hBEEF;
    tick();
    write_en = 5'd0; bus_in = 16'h0000;
    n_tests++;
    if ({mem_req, mem_sel, busy, dbg_state} !== 4'b1011) begin
      n_fail++; $display("FAIL dm_launch req/sel/busy/st got=%b exp=1011", {mem_req, mem_sel, busy, dbg_state});
    end
    n_tests++;
    if (mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL dm_addr_data got=%h/%h exp=0040/beef", mem_addr, mem_wdata);
    end
    n_tests++;
    if (dar !== exp_regs[1]) begin
      n_fail++; $display("FAIL dm_dar_hold got=%h exp=%h", dar, exp_regs[1]);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_err !== 1'b0) begin
        n_fail++; $display("FAIL dm_wait%0d req/err got=%b%b exp=10", k, mem_req, mem_err);
      end
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++;
    if ({mem_req, busy, mem_err, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL dm_ack req/busy/err/st got=%b exp=0000", {mem_req, busy, mem_err, dbg_state});
    end
    tick();
    n_tests++;
    if (mem_err !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL dm_post err/req got=%b%b exp=00", mem_err, mem_req);
    end
  endtask

  task automatic test_timeout();
    int high_cnt;
    bit done;
    write_en = 5'd17; bus_in = 16'h1357;
    tick();
    write_en = 5'd0;
    n_tests++;
    if (mem_req !== 1'b1 || mem_sel !== 1'b1 || mem_addr !== exp_regs[0] || mem_wdata !== 16'h1357) begin
      n_fail++; $display("FAIL im_launch req=%b sel=%b addr=%h data=%h exp 1 1 %h 1357",
                         mem_req, mem_sel, mem_addr, mem_wdata, exp_regs[0]);
    end
    high_cnt = 1; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      write_en = (k == 2) ? 5'd16 : 5'd0;
      bus_in   = (k == 2) ? 16'h2222 : 16'h0000;
      tick();
      write_en = 5'd0;
      if (mem_req) begin
        high_cnt++;
        n_tests++;
        if (mem_addr !== exp_regs[0] || mem_wdata !== 16'h1357 || mem_err !== 1'b0) begin
          n_fail++; $display("FAIL im_hold addr=%h data=%h err=%b exp %h 1357 0", mem_addr, mem_wdata, mem_err, exp_regs[0]);
        end
      end else begin
        done = 1;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL im_timeout_bound req still high after 40 cycles");
    end
    n_tests++;
    if (high_cnt != 15) begin
      n_fail++; $display("FAIL im_req_cycles got=%0d exp=15", high_cnt);
    end
    n_tests++;
    if (mem_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL im_err_pulse err/busy got=%b%b exp=10", mem_err, busy);
    end
    tick();
    n_tests++;
    if (mem_err !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL im_err_end err/req got=%b%b exp=00", mem_err, mem_req);
    end
  endtask

  task automatic test_ack_at_timeout();
    write_en = 5'd16; bus_in = 16'h0A0A;
    tick();
    write_en = 5'd0;
    for (int k = 0; k < 14; k++) tick();
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL edge_req_before got=%b exp=1", mem_req);
    end
    mem_ack = 1'b1; write_en = 5'd17; bus_in = 16'h5555;
    tick();
    mem_ack = 1'b0; write_en = 5'd0;
    n_tests++;
    if ({mem_req, busy, mem_err} !== 3'b000) begin
      n_fail++; $display("FAIL edge_ack_wins req/busy/err got=%b exp=000", {mem_req, busy, mem_err});
    end
    write_en = 5'd17; bus_in = 16'h7777;
    tick();
    write_en = 5'd0;
    n_tests++;
    if (mem_req !== 1'b1 || mem_sel !== 1'b1 || mem_wdata !== 16'h7777) begin
      n_fail++; $display("FAIL b2b_launch req=%b sel=%b data=%h exp 1 1 7777", mem_req, mem_sel, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done req/err got=%b%b exp=00", mem_req, mem_err);
    end
  endtask

  task automatic test_busy_loads_reset();
    write_en = 5'd16; bus_in = 16'h4444;
    tick();
    write_en = 5'd4; bus_in = 16'h0005;
    tick();
    write_en = 5'd0;
    exp_regs[3] = 16'h0005;
    n_tests++;
    if (ac !== exp_regs[3] || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL busy_load ac=%h req=%b exp 0005 1", ac, mem_req);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) exp_regs[i] = '0;
    n_tests++;
    if ({mem_req, busy, dbg_state} !== 3'b000 || ac !== 16'h0000) begin
      n_fail++; $display("FAIL midop_reset req/busy/st=%b ac=%h exp 000 0000", {mem_req, busy, dbg_state}, ac);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++;
    if ({mem_req, busy, mem_err, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL late_ack req/busy/err/st got=%b exp=0000", {mem_req, busy, mem_err, dbg_state});
    end
  endtask

`ifdef PC_INC_EN
  task automatic test_pc_inc();
    write_en = 5'd1; bus_in = 16'hFFFF;
    tick();
    write_en = 5'd0; inc_pc = 1'b1;
    tick();
    n_tests++;
    if (pc !== 16'h0000) begin
      n_fail++; $display("FAIL pc_wrap got=%h exp=0000", pc);
    end
    write_en = 5'd1; bus_in = 16'h0100;
    tick();
    n_tests++;
    if (pc !== 16'h0100) begin
      n_fail++; $display("FAIL pc_load_wins got=%h exp=0100", pc);
    end
    write_en = 5'd0;
    tick();
    inc_pc = 1'b0;
    n_tests++;
    if (pc !== 16'h0101) begin
      n_fail++; $display("FAIL pc_inc got=%h exp=0101", pc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_dm_write();
    test_timeout();
    test_ack_at_timeout();
    test_busy_loads_reset();
`ifdef PC_INC_EN
    test_pc_inc();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
